// File: rtl/timer.sv
// timer: prescaled 4-bit countdown with tick/expired flags; define TIMER_AUTO_RELOAD_EN for a repeating countdown
module timer #(
  parameter int unsigned TICKS_PER_UNIT = 50_000_000,
  parameter logic [3:0] START_VALUE = 4'd15
) (
  input logic clk,
  input logic reset,
  input logic enable,
  output logic [3:0] newTime,
  output logic tick,
  output logic expired
);
  localparam int W = TICKS_PER_UNIT > 1 ? $clog2(TICKS_PER_UNIT) : 1;
  localparam logic [W-1:0] LAST = W'(TICKS_PER_UNIT - 1);
  logic [W-1:0] cnt;
  logic run;
  logic wrap;
`ifdef TIMER_AUTO_RELOAD_EN
  assign run = enable;
`else
  assign run = enable && !expired;
`endif
  assign wrap = run && cnt == LAST;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      newTime <= START_VALUE;
      tick <= 1'b0;
      expired <= 1'b0;
    end else begin
      tick <= wrap;
      if (run) cnt <= wrap ? '0 : cnt + 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
      if (wrap) newTime <= newTime == 4'd0 ? START_VALUE : newTime - 1'b1;
      expired <= wrap && newTime == 4'd1;
`else
      if (wrap && newTime != 4'd0) newTime <= newTime - 1'b1;
      if (wrap && newTime == 4'd1) expired <= 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_timer.sv
// tb_timer: directed self-checking bench for timer (TICKS_PER_UNIT=4 and =1)
module tb_timer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic [3:0] nt4;
  logic [3:0] nt1;
  logic tick4, tick1, exp4, exp1;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  timer #(.TICKS_PER_UNIT(4), .START_VALUE(4'd15)) u_t4 (
    .clk(clk), .reset(reset), .enable(enable), .newTime(nt4), .tick(tick4), .expired(exp4)
  );
  timer #(.TICKS_PER_UNIT(1), .START_VALUE(4'd15)) u_t1 (
    .clk(clk), .reset(reset), .enable(enable), .newTime(nt1), .tick(tick1), .expired(exp1)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, want);
  endtask
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset(input logic en);
    reset = 1'b1;
    enable = en;
    step(1);
    reset = 1'b0;
  endtask
  initial begin
    do_reset(1'b0);
    check("rst_nt4", 32'(nt4), 15);
    check("rst_tick4", 32'(tick4), 0);
    check("rst_exp4", 32'(exp4), 0);
    check("rst_nt1", 32'(nt1), 15);
    enable = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      step(1);
      check("t1_nt", 32'(nt1), 32'(15 - i));
      check("t1_tick", 32'(tick1), 1);
      check("t1_exp", 32'(exp1), i == 15 ? 1 : 0);
    end
    check("t4_after15", 32'(nt4), 12);
    do_reset(1'b1);
    check("rst_exp_nt1", 32'(nt1), 15);
    check("rst_exp_exp1", 32'(exp1), 0);
    check("rst_run_nt4", 32'(nt4), 15);
    check("rst_run_tick4", 32'(tick4), 0);
    enable = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step(1);
      check("first_nt", 32'(nt4), 15);
      check("first_tick", 32'(tick4), 0);
    end
    step(1);
    check("e4_nt", 32'(nt4), 14);
    check("e4_tick", 32'(tick4), 1);
    step(1);
    check("e5_tick", 32'(tick4), 0);
    check("e5_nt", 32'(nt4), 14);
    step(54);
    check("e59_nt", 32'(nt4), 1);
    check("e59_exp", 32'(exp4), 0);
    step(1);
    check("e60_nt", 32'(nt4), 0);
    check("e60_exp", 32'(exp4), 1);
    check("e60_tick", 32'(tick4), 1);
`ifdef TIMER_AUTO_RELOAD_EN
    step(1);
    check("ar_e61_exp", 32'(exp4), 0);
    check("ar_e61_nt", 32'(nt4), 0);
    step(3);
    check("ar_e64_nt", 32'(nt4), 15);
    check("ar_e64_tick", 32'(tick4), 1);
    check("ar_e64_exp", 32'(exp4), 0);
    step(4);
    check("ar_e68_nt", 32'(nt4), 14);
`else
    for (int i = 1; i <= 20; i++) begin
      enable = i > 10 ? 1'b0 : 1'b1;
      step(1);
      check("hold_nt", 32'(nt4), 0);
      check("hold_exp", 32'(exp4), 1);
      check("hold_tick", 32'(tick4), 0);
    end
`endif
    do_reset(1'b0);
    enable = 1'b1;
    step(29);
    check("e29_nt", 32'(nt4), 8);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("mid_rst_nt", 32'(nt4), 15);
    check("mid_rst_exp", 32'(exp4), 0);
    check("mid_rst_tick", 32'(tick4), 0);
    step(3);
    check("post_rst_e3", 32'(nt4), 15);
    step(1);
    check("post_rst_e4", 32'(nt4), 14);
    check("post_rst_tick", 32'(tick4), 1);
    do_reset(1'b0);
    enable = 1'b1;
    step(2);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("pause_nt", 32'(nt4), 15);
      check("pause_tick", 32'(tick4), 0);
    end
    enable = 1'b1;
    step(1);
    check("resume1_nt", 32'(nt4), 15);
    step(1);
    check("resume2_nt", 32'(nt4), 14);
    check("resume2_tick", 32'(tick4), 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
